// File: rtl/nibble_serial_alu.sv
// Nibble-serial add/subtract sequencer: feeds a 4-bit carry-lookahead slice one
// nibble per clock (LSB first) and assembles the WIDTH-bit result and flags.
module nibble_serial_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             SF,
    output logic             CF,
    output logic             OF,
    output logic             PF,
    output logic             ZF
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_sr;
    logic [CW-1:0]    k;
    logic             carry;
    logic             sub_op;
    logic             zacc;
    logic             pacc;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       gen;
    logic [3:0]       prop;
    logic [4:0]       c;
    logic [3:0]       slice_sum;
    logic             slice_cf;
    logic             slice_of;
    logic             slice_zf;
    logic             slice_pf;
    logic [WIDTH-1:0] sum_next;
    logic             last;

    // 4-bit carry-lookahead slice operating on nibble k of the latched operands
    always_comb begin
        nib_a = a_reg[4*k +: 4];
        nib_b = b_reg[4*k +: 4];
        gen   = nib_a & nib_b;
        prop  = nib_a ^ nib_b;
        c[0]  = carry;
        c[1]  = gen[0] | (prop[0] & carry);
        c[2]  = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry);
        c[3]  = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & carry);
        c[4]  = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
              | (prop[3] & prop[2] & prop[1] & gen[0])
              | (prop[3] & prop[2] & prop[1] & prop[0] & carry);
        slice_sum = prop ^ c[3:0];
        slice_cf  = c[4];
        slice_of  = c[4] ^ c[3];
        slice_zf  = (slice_sum == 4'h0);
        slice_pf  = ^slice_sum;
        sum_next  = (sum_sr >> 4) | (WIDTH'(slice_sum) << (WIDTH - 4));
        last      = (k == CW'(NIB - 1));
    end

    // Sequencer; outputs only move on the final nibble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            sum_sr <= '0;
            k      <= '0;
            carry  <= 1'b0;
            sub_op <= 1'b0;
            zacc   <= 1'b0;
            pacc   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            SF     <= 1'b0;
            CF     <= 1'b0;
            OF     <= 1'b0;
            PF     <= 1'b0;
            ZF     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= op[1] ? ~b : b;
                        carry  <= op[1] ^ (op[0] & cin);
                        sub_op <= op[1];
                        k      <= '0;
                        zacc   <= 1'b1;
                        pacc   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_sr <= sum_next;
                    carry  <= slice_cf;
                    zacc   <= zacc & slice_zf;
                    pacc   <= pacc ^ slice_pf;
                    k      <= k + CW'(1);
                    if (last) begin
                        result <= sum_next;
                        SF     <= sum_next[WIDTH-1];
                        OF     <= slice_of;
                        ZF     <= zacc & slice_zf;
                        PF     <= pacc ^ slice_pf;
                        CF     <= slice_cf ^ sub_op;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        k      <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed bench for nibble_serial_alu at WIDTH=16: results, flags, latency,
// start-while-busy and mid-operation reset.
module tb_nibble_serial_alu;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] ADC = 2'b01;
    localparam logic [1:0] SUB = 2'b10;
    localparam logic [1:0] SBB = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        SF, CF, OF, PF, ZF;

    int checks = 0;
    int errors = 0;

    nibble_serial_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .result(result),
        .SF(SF), .CF(CF), .OF(OF), .PF(PF), .ZF(ZF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {SF, CF, OF, PF, ZF};
    endfunction

    // Launch one operation, wait (bounded) for done, then check outputs.
    // Returns at #1 after the completion edge, i.e. inside the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic c,
                          input logic [15:0] exp_res, input logic [4:0] exp_flags);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; cin = c;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".done_early"}, 32'(done), 32'd0);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'd4);
        check({tag, ".result"}, 32'(result), 32'(exp_res));
        check({tag, ".flags"}, 32'(flags()), 32'(exp_flags));
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int done_seen;
        rst = 1'b1; start = 1'b0; op = ADD; a = '0; b = '0; cin = 1'b0;
        #12;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.flags", 32'(flags()), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Flags are packed {SF, CF, OF, PF, ZF}; back-to-back launches in the done cycle
        run_op("add_5555", ADD, 16'h1234, 16'h4321, 1'b0, 16'h5555, 5'b00000);
        run_op("add_wrap", ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b01001);
        run_op("add_ovf",  ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b10110);
        run_op("sub_brw",  SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 5'b11000);
        run_op("sbb_brw",  SBB, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 5'b11000);
        run_op("adc_cin",  ADC, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 5'b00010);

        // done is a single-cycle pulse; result holds afterwards
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("hold.result", 32'(result), 32'h0100);

        // start with new operands while busy must be ignored
        @(negedge clk);
        start = 1'b1; op = ADD; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = SUB; a = 16'hFFFF; b = 16'h0001; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_ign.no_early", 32'(result), 32'h0100);
        cyc = 2;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("busy_ign.latency", 32'(cyc), 32'd4);
        check("busy_ign.result", 32'(result), 32'h3333);
        check("busy_ign.flags", 32'(flags()), 32'd0);
        @(posedge clk); #1;
        check("busy_ign.idle", 32'(busy), 32'd0);

        // Reset after the second nibble edge aborts the operation
        @(negedge clk);
        start = 1'b1; op = ADD; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.result", 32'(result), 32'd0);
        check("rst_mid.flags", 32'(flags()), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            if (done) done_seen++;
        end
        check("rst_mid.no_done", 32'(done_seen), 32'd0);
        check("rst_mid.result_hold", 32'(result), 32'd0);

        run_op("add_after_rst", ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 5'b00010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
